// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bundle: byte handshake plus open-drain line pins.
// Master is the system side, slave is the transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output tx_data,
        output tx_valid,
        output ps2_clk_in,
        output ps2_dat_in,
        input  tx_ready,
        input  tx_done,
        input  tx_error,
        input  ps2_clk_oe,
        input  ps2_dat_oe
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  ps2_clk_in,
        input  ps2_dat_in,
        output tx_ready,
        output tx_done,
        output tx_error,
        output ps2_clk_oe,
        output ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, start, 8 data, parity, stop, ack).
// Optional: define PS2_HOST_TX_TIMEOUT_EN to abort stalled transfers.
module ps2_host_tx #(
    parameter int CLK_HOLD_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES  = 750000
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    ps2_host_tx_if.slave bus
);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int CNT_MAX = (CLK_HOLD_CYCLES > TIMEOUT_CYCLES) ?
                             CLK_HOLD_CYCLES : TIMEOUT_CYCLES;
`else
    localparam int CNT_MAX = CLK_HOLD_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLK_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(CLK_HOLD_CYCLES - 2);
    localparam logic DAT_AT_ENTRY = (CLK_HOLD_CYCLES == 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_tx_ready;
    logic             r_tx_done;
    logic             r_tx_error;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_data;
    logic             r_par;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_d;
    logic             r_dat_s1;
    logic             r_dat_s2;

    logic             w_fall;
    logic [9:0]       w_frame;
    logic [3:0]       w_nxt_idx;
    logic             w_nxt_bit;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    logic             w_waiting;
`endif

    // Bring the raw lines into the clock domain and keep last clk for edge detect.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= bus.ps2_dat_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_d & ~r_clk_s2;
    // Bit order on the wire after the start bit: data LSB first, parity, stop.
    assign w_frame   = {1'b1, r_par, r_data};
    assign w_nxt_idx = r_idx + 4'd1;
    assign w_nxt_bit = w_frame[w_nxt_idx];
`ifdef PS2_HOST_TX_TIMEOUT_EN
    assign w_waiting = (r_state == START) || (r_state == BITS) ||
                       (r_state == ACK)   || (r_state == WAIT_IDLE);
`endif

    // Transfer sequencer; every output is a register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_idx      <= 4'd0;
            r_cnt      <= '0;
            r_data     <= 8'd0;
            r_par      <= 1'b0;
        end else begin
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            if (w_waiting) begin
                r_cnt <= r_cnt + 1'b1;
            end
`endif
            unique case (r_state)
                IDLE: begin
                    // Ready drops for one cycle after returning, so a
                    // request is only taken once ready is visible.
                    if (r_tx_ready && bus.tx_valid) begin
                        r_data     <= bus.tx_data;
                        r_par      <= ~^bus.tx_data;
                        r_tx_ready <= 1'b0;
                        r_clk_oe   <= 1'b1;
                        r_dat_oe   <= DAT_AT_ENTRY;
                        r_cnt      <= '0;
                        r_state    <= INHIBIT;
                    end else begin
                        r_tx_ready <= 1'b1;
                        r_clk_oe   <= 1'b0;
                        r_dat_oe   <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_clk_oe <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == HOLD_PRE) begin
                            r_dat_oe <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (w_fall) begin
                        r_idx    <= 4'd0;
                        r_dat_oe <= ~r_data[0];
                        r_cnt    <= '0;
                        r_state  <= BITS;
                    end
                end
                BITS: begin
                    if (w_fall) begin
                        r_cnt <= '0;
                        if (r_idx == 4'd9) begin
                            r_dat_oe <= 1'b0;
                            r_idx    <= 4'd0;
                            r_state  <= ACK;
                        end else begin
                            r_idx    <= w_nxt_idx;
                            r_dat_oe <= ~w_nxt_bit;
                        end
                    end
                end
                ACK: begin
                    if (w_fall) begin
                        r_cnt <= '0;
                        if (!r_dat_s2) begin
                            r_state <= WAIT_IDLE;
                        end else begin
                            r_tx_error <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (r_clk_s2 && r_dat_s2) begin
                        r_tx_done <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
            // A stalled device overrides whatever the state would do this cycle.
            if (w_waiting && (r_cnt == TO_LAST)) begin
                r_clk_oe   <= 1'b0;
                r_dat_oe   <= 1'b0;
                r_idx      <= 4'd0;
                r_cnt      <= '0;
                r_tx_done  <= 1'b0;
                r_tx_error <= 1'b1;
                r_state    <= IDLE;
            end
`endif
        end
    end

    assign bus.tx_ready   = r_tx_ready;
    assign bus.tx_done    = r_tx_done;
    assign bus.tx_error   = r_tx_error;
    assign bus.ps2_clk_oe = r_clk_oe;
    assign bus.ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on open-drain lines, frame model, pulse monitor.
// Covers the timeout path too when PS2_HOST_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;
    localparam int HOLD = 5000;
    localparam int TMO  = 1000;
    localparam int HALF = 10;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_dat  = 1'b1;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .CLK_HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_dat_in = dev_dat & ~bus.ps2_dat_oe;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       hold_valid;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int done_seen = 0;
    int err_seen  = 0;
    int both_seen = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (bus.tx_done)  done_seen <= done_seen + 1;
        if (bus.tx_error) err_seen  <= err_seen + 1;
        if (bus.tx_done && bus.tx_error) both_seen <= both_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line image the device expects: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Device clocks n cycles, sampling DAT just before each falling edge.
    task automatic dev_clocks(input int n, output logic [10:0] fr);
        fr = '0;
        for (int k = 0; k < n; k++) begin
            repeat (HALF) @(negedge CLOCK_50);
            if (k < 11) fr[k] = bus.ps2_dat_in;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
            dev_clk = 1'b1;
        end
    endtask

    task automatic dev_ack(input logic ack);
        repeat (HALF) @(negedge CLOCK_50);
        dev_dat = ~ack;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_dat = 1'b1;
    endtask

    task automatic start_req(input logic [7:0] d);
        @(negedge CLOCK_50);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic do_xfer(input vec_t v, input string tag);
        logic [10:0] fr;
        int n, dcnt, t, d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        start_req(v.data);
        check({tag, " ready_drop"}, bus.tx_ready, 0);
        if (!v.hold_valid) bus.tx_valid = 1'b0;
        n = 0;
        dcnt = 0;
        t = 0;
        while (bus.ps2_clk_oe && t < HOLD + 100) begin
            n++;
            t++;
            if (bus.ps2_dat_oe) dcnt++;
            if (v.hold_valid) bus.tx_data = 8'($urandom);
            @(negedge CLOCK_50);
        end
        bus.tx_valid = 1'b0;
        check({tag, " hold_len"}, n, HOLD);
        check({tag, " dat_on_last_hold"}, dcnt, 1);
        check({tag, " start_bit"}, bus.ps2_dat_oe, 1);
        dev_clocks(11, fr);
        check({tag, " frame"}, fr, model_frame(v.data));
        dev_ack(v.ack);
        t = 0;
        while (!bus.tx_ready && t < 100) begin
            t++;
            @(negedge CLOCK_50);
        end
        @(negedge CLOCK_50);
        check({tag, " done_cnt"}, done_seen - d0, v.exp_done);
        check({tag, " err_cnt"}, err_seen - e0, v.exp_err);
        check({tag, " ready_end"}, bus.tx_ready, 1);
        check({tag, " oe_end"}, {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    endtask

    initial begin
        #(120000 * 20);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        logic [10:0] fr;
        int t, d0, e0, t0;

        tbl[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};

        bus.tx_data  = 8'd0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst ready", bus.tx_ready, 1);
        check("rst pulses", {bus.tx_done, bus.tx_error}, 0);
        check("rst oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("idle ready", bus.tx_ready, 1);

        for (int i = 0; i < 5; i++) begin
            do_xfer(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            v.data       = 8'($urandom);
            v.ack        = 1'($urandom);
            v.hold_valid = 1'b0;
            v.exp_done   = v.ack;
            v.exp_err    = ~v.ack;
            do_xfer(v, $sformatf("rnd%0d", i));
        end

        // Reset while bit index 4 of 0x00 is on the wire.
        d0 = done_seen;
        e0 = err_seen;
        start_req(8'h00);
        bus.tx_valid = 1'b0;
        t = 0;
        while (bus.ps2_clk_oe && t < HOLD + 100) begin
            t++;
            @(negedge CLOCK_50);
        end
        dev_clocks(5, fr);
        check("mid dat_oe", bus.ps2_dat_oe, 1);
        #3 resetn = 1'b0;
        #1;
        check("async oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        check("async ready", bus.tx_ready, 1);
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst no done", done_seen - d0, 0);
        check("rst no err", err_seen - e0, 0);
        v = '{8'h96, 1'b1, 1'b0, 1'b1, 1'b0};
        do_xfer(v, "after_rst");

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Device never clocks: abort must land a fixed time after START.
        e0 = err_seen;
        start_req(8'h42);
        bus.tx_valid = 1'b0;
        t = 0;
        while (bus.ps2_clk_oe && t < HOLD + 100) begin
            t++;
            @(negedge CLOCK_50);
        end
        t0 = cyc;
        t = 0;
        while (!bus.tx_error && t < 3 * TMO) begin
            t++;
            @(negedge CLOCK_50);
        end
        check("tmo delay", cyc - t0, TMO);
        check("tmo oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        repeat (3) @(negedge CLOCK_50);
        check("tmo err", err_seen - e0, 1);
        check("tmo ready", bus.tx_ready, 1);
`else
        t0 = 0;
`endif

        check("never both", both_seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
